// File: rtl/dmx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmx_pkg
//  Purpose : Shared definitions for the DMX512 transmit path: controller
//            state encoding, DMX line timing in microseconds, slot limits
//            and a helper that turns a microsecond time into sys_clk cycles.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package dmx_pkg;

    // Controller states, explicitly encoded in 4 bits
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BREAK     = 4'd1,
        ST_MAB       = 4'd2,
        ST_LOAD_SC   = 4'd3,
        ST_SEND      = 4'd4,
        ST_FETCH     = 4'd5,
        ST_WAIT_DATA = 4'd6,
        ST_LOAD      = 4'd7,
        ST_MTBP      = 4'd8
    } dmx_state_t;

    // DMX line timing in microseconds
    localparam int c_bit_us   = 4;    // 250 kbaud
    localparam int c_break_us = 100;
    localparam int c_mab_us   = 12;
    localparam int c_mtbp_us  = 10;

    // Largest number of data slots in a packet
    localparam int c_max_slots = 512;

    // Start bit + 8 data bits + 2 stop bits
    localparam int c_frame_bits = 11;

    // Microseconds to sys_clk cycles; 64-bit product so 100 MHz * 100 us
    // does not overflow.
    function automatic int us_to_cycles(input longint hz, input int us);
        longint l_prod;
        l_prod = hz * longint'(us);
        return int'(l_prod / 64'sd1000000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmx_tx_ser.sv
`default_nettype none
// ============================================================================
//  Module  : dmx_tx_ser
//  Purpose : 250 kbaud 8N2 serializer. A load pulse captures a byte; the
//            start bit appears on tx the next cycle, followed by d0..d7
//            (LSB first) and two stop bits, each BIT_CYCLES long.
//  Ports   : sys_clk, sys_rst (async, active-high)
//            load   - one-cycle request to send data
//            data   - byte captured on load
//            tx     - serial line, idle mark = 1
//            busy   - high while a character is on the line
//            done   - high on the last cycle of the second stop bit
//  Rev     : 1.0  initial release
// ============================================================================
module dmx_tx_ser
    import dmx_pkg::*;
#(
    parameter int BIT_CYCLES = 400
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] c_bit_last   = 16'(BIT_CYCLES - 1);
    localparam logic [3:0]  c_shift_last = 4'(c_frame_bits - 1);

    // Bit 0 of the shift register is the line; ones are shifted in from the
    // top, so the register naturally returns to all-ones (mark) at the end.
    logic [10:0] r_shift;
    logic [15:0] r_cnt;
    logic [3:0]  r_bits_left;
    logic        r_busy;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_shift     <= '1;
            r_cnt       <= '0;
            r_bits_left <= '0;
            r_busy      <= 1'b0;
        end else if (load) begin
            r_shift     <= {2'b11, data, 1'b0};
            r_cnt       <= c_bit_last;
            r_bits_left <= c_shift_last;
            r_busy      <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == 16'd0) begin
                if (r_bits_left == 4'd0) begin
                    r_busy <= 1'b0;
                end else begin
                    r_shift     <= {1'b1, r_shift[10:1]};
                    r_bits_left <= r_bits_left - 4'd1;
                    r_cnt       <= c_bit_last;
                end
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign tx   = r_shift[0];
    assign busy = r_busy;
    assign done = r_busy && (r_cnt == 16'd0) && (r_bits_left == 4'd0);

endmodule
`default_nettype wire

// File: rtl/dmx_tx_ctl.sv
`default_nettype none
// ============================================================================
//  Module  : dmx_tx_ctl
//  Purpose : DMX512 transmit frame controller. Sends break, mark-after-break,
//            start code, channel_count slots read from the channel RAM and
//            the inter-packet mark, repeating while enable is high.
//  Ports   : sys_clk, sys_rst (async, active-high)
//            enable        - frames are sent back to back while high
//            start_code    - slot-0 value, latched at frame start
//            channel_count - data slots (0 = 512), latched at frame start
//            ram_a         - channel RAM read address (registered)
//            ram_do        - channel RAM data, valid one cycle after ram_a
//            tx            - DMX line, idle mark = 1
//            busy          - high from break start to end of MTBP
//            frame_done    - one-cycle pulse on the last MTBP cycle
//  Rev     : 1.0  initial release
// ============================================================================
module dmx_tx_ctl
    import dmx_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BIT_CYCLES   = us_to_cycles(CLK_FREQ, c_bit_us),
    parameter int BREAK_CYCLES = us_to_cycles(CLK_FREQ, c_break_us),
    parameter int MAB_CYCLES   = us_to_cycles(CLK_FREQ, c_mab_us),
    parameter int MTBP_CYCLES  = us_to_cycles(CLK_FREQ, c_mtbp_us)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       enable,
    input  logic [7:0] start_code,
    input  logic [8:0] channel_count,
    output logic [8:0] ram_a,
    input  logic [7:0] ram_do,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] c_break_last = 16'(BREAK_CYCLES - 1);
    // LOAD_SC is also a mark cycle on the line, so the MAB state itself is
    // one cycle shorter to keep the visible mark at exactly MAB_CYCLES.
    localparam logic [15:0] c_mab_last   = 16'(MAB_CYCLES - 2);
    localparam logic [15:0] c_mtbp_last  = 16'(MTBP_CYCLES - 1);

    dmx_state_t  r_state;
    logic [15:0] r_cnt;
    logic [9:0]  r_slot;        // data slots handed to the serializer
    logic [9:0]  r_count;       // latched data slot count, 1..512
    logic [7:0]  r_start_code;
    logic [8:0]  r_ram_a;
    logic        r_line;        // registered line level outside of slots
    logic        r_busy;
    logic        r_frame_done;

    logic        w_ser_load;
    logic [7:0]  w_ser_data;
    logic        w_ser_tx;
    logic        w_ser_busy;
    logic        w_ser_done;
    logic        w_frame_start;

    assign w_ser_load    = (r_state == ST_LOAD_SC) || (r_state == ST_LOAD);
    assign w_ser_data    = (r_state == ST_LOAD) ? ram_do : r_start_code;
    assign w_frame_start = enable && ((r_state == ST_IDLE) ||
                           ((r_state == ST_MTBP) && (r_cnt == 16'd0)));

    dmx_tx_ser #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_ser (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (w_ser_load),
        .data    (w_ser_data),
        .tx      (w_ser_tx),
        .busy    (w_ser_busy),
        .done    (w_ser_done)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_count      <= '0;
            r_start_code <= '0;
            r_ram_a      <= '0;
            r_line       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_line <= 1'b1;
                end
                ST_BREAK: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_MAB;
                        r_cnt   <= c_mab_last;
                        r_line  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_MAB: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_LOAD_SC;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_LOAD_SC: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_ser_done) begin
                        if (r_slot == r_count) begin
                            r_state <= ST_MTBP;
                            r_cnt   <= c_mtbp_last;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Wraps 511 -> 0 after the last slot of a full frame
                    r_ram_a <= r_ram_a + 9'd1;
                    r_slot  <= r_slot + 10'd1;
                    r_state <= ST_SEND;
                end
                ST_MTBP: begin
                    if (r_cnt == 16'd1) begin
                        r_frame_done <= 1'b1;
                    end
                    if (r_cnt == 16'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_line  <= 1'b1;
                end
            endcase

            // Frame start overrides the IDLE / end-of-MTBP decisions above
            if (w_frame_start) begin
                r_state      <= ST_BREAK;
                r_cnt        <= c_break_last;
                r_line       <= 1'b0;
                r_busy       <= 1'b1;
                r_ram_a      <= '0;
                r_slot       <= '0;
                r_start_code <= start_code;
                r_count      <= (channel_count == 9'd0) ? 10'(c_max_slots)
                                                        : {1'b0, channel_count};
            end
        end
    end

    // The serializer rests at mark, so it owns the line only while a
    // character is in flight; otherwise the registered level is driven.
    assign tx         = w_ser_busy ? w_ser_tx : r_line;
    assign ram_a      = r_ram_a;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dmx_tx_ctl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmx_tx_ctl
//  Purpose : Self-checking bench for dmx_tx_ctl at a 2.5 MHz clock
//            (bit=10, break=250, MAB=30, MTBP=25 cycles). Expected slot bytes
//            are queued when a frame is requested and popped as slots decode.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmx_tx_ctl;

    logic       sys_clk;
    logic       sys_rst;
    logic       enable;
    logic [7:0] start_code;
    logic [8:0] channel_count;
    logic [8:0] ram_a;
    logic [7:0] ram_do;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0]  mem [512];
    logic [7:0]  exp_q [$];
    logic [10:0] slot1_bits;
    int          total;
    int          bad;

    typedef struct {
        logic [7:0] sc;
        logic [8:0] cnt;
        logic [7:0] ram0;
        int         slots;   // start code + data slots expected on the line
    } vec_t;
    vec_t tbl [4];

    dmx_tx_ctl #(
        .CLK_FREQ (2500000)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .start_code    (start_code),
        .channel_count (channel_count),
        .ram_a         (ram_a),
        .ram_do        (ram_do),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous-read channel RAM
    always @(posedge sys_clk) ram_do <= mem[ram_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (tx === lvl && n < 1000) begin
            n++;
            @(negedge sys_clk);
        end
    endtask

    task automatic push_frame(input logic [7:0] sc, input int n_data);
        exp_q.push_back(sc);
        for (int k = 0; k < n_data; k++) exp_q.push_back(mem[k]);
    endtask

    // Decodes one whole frame from the line starting at or before the
    // break; returns positioned on the cycle after frame_done.
    task automatic check_frame(input int n_data, input bit expect_next);
        int          n;
        int          t;
        logic        ok;
        logic [10:0] bits;
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        if (tx !== 1'b0) begin
            chk("break_start", 32'(tx), 32'd0);
            return;
        end
        count_level(1'b0, n);
        chk("break_len", n, 250);
        count_level(1'b1, n);
        chk("mab_len", n, 30);
        for (int s = 0; s <= n_data; s++) begin
            if (s > 0) begin
                count_level(1'b1, n);
                chk("gap_len", n, 3);
            end
            chk("slot_ram_a", 32'(ram_a), 32'(s % 512));
            chk("slot_busy", 32'(busy), 32'd1);
            ok = 1'b1;
            for (int b = 0; b < 11; b++) begin
                bits[b] = tx;
                for (int c = 0; c < 10; c++) begin
                    if (tx !== bits[b]) ok = 1'b0;
                    @(negedge sys_clk);
                end
            end
            chk("bit_timing", 32'(ok), 32'd1);
            chk("start_bit", 32'(bits[0]), 32'd0);
            chk("stop_bits", 32'(bits[10:9]), 32'd3);
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
            end else begin
                chk("slot_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
            end
            if (s == 1) slot1_bits = bits;
        end
        n  = 0;
        ok = 1'b1;
        while (n < 1000) begin
            n++;
            if (tx !== 1'b1) ok = 1'b0;
            if (frame_done === 1'b1) break;
            @(negedge sys_clk);
        end
        chk("mtbp_len", n, 25);
        chk("mtbp_mark", 32'(ok), 32'd1);
        @(negedge sys_clk);
        chk("fd_pulse_width", 32'(frame_done), 32'd0);
        if (expect_next) begin
            chk("b2b_break_tx", 32'(tx), 32'd0);
            chk("b2b_busy", 32'(busy), 32'd1);
        end else begin
            chk("end_tx", 32'(tx), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        total = 0;
        bad   = 0;
        tbl[0] = '{sc: 8'h00, cnt: 9'd3, ram0: 8'h11, slots: 4};
        tbl[1] = '{sc: 8'hA5, cnt: 9'd1, ram0: 8'h01, slots: 2};
        tbl[2] = '{sc: 8'h3C, cnt: 9'd7, ram0: 8'h80, slots: 8};
        tbl[3] = '{sc: 8'hFF, cnt: 9'd0, ram0: 8'h11, slots: 513};
        for (int i = 0; i < 512; i++) mem[i] = 8'((i * 37) + 5);
        mem[1] = 8'h22;
        mem[2] = 8'h33;

        sys_rst       = 1'b1;
        enable        = 1'b0;
        start_code    = 8'h00;
        channel_count = 9'd0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Table of single frames
        for (int i = 0; i < 4; i++) begin
            mem[0] = tbl[i].ram0;
            @(negedge sys_clk);
            start_code    = tbl[i].sc;
            channel_count = tbl[i].cnt;
            enable        = 1'b1;
            push_frame(tbl[i].sc, tbl[i].slots - 1);
            @(negedge sys_clk);
            enable = 1'b0;
            check_frame(tbl[i].slots - 1, 1'b0);
            if (i == 1) chk("bit_order", 32'(slot1_bits), 32'(11'b110_0000_0010));
            if (tbl[i].slots == 513) chk("full_wrap_ram_a", 32'(ram_a), 32'd0);
        end
        mem[0] = 8'h11;

        // Back-to-back with a mid-frame start code / count change
        @(negedge sys_clk);
        start_code    = 8'h5A;
        channel_count = 9'd2;
        enable        = 1'b1;
        push_frame(8'h5A, 2);
        @(negedge sys_clk);
        fork
            check_frame(2, 1'b1);
            begin
                repeat (100) @(negedge sys_clk);
                start_code    = 8'hC3;
                channel_count = 9'd5;
                push_frame(8'hC3, 5);
            end
        join
        // Second frame: drop enable during data slot 2
        fork
            check_frame(5, 1'b0);
            begin
                repeat (520) @(negedge sys_clk);
                enable = 1'b0;
            end
        join
        ok = 1'b1;
        repeat (300) begin
            @(negedge sys_clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("idle_after_drop", 32'(ok), 32'd1);

        // Reset during a data start bit
        @(negedge sys_clk);
        start_code    = 8'h42;
        channel_count = 9'd2;
        enable        = 1'b1;
        push_frame(8'h42, 2);
        repeat (395) @(negedge sys_clk);
        chk("pre_reset_tx_low", 32'(tx), 32'd0);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge sys_clk);
        chk("rst_ram_a_mid", 32'(ram_a), 32'd0);
        chk("rst_fd_mid", 32'(frame_done), 32'd0);
        push_frame(8'h42, 2);
        sys_rst = 1'b0;
        fork
            check_frame(2, 1'b0);
            begin
                @(negedge sys_clk);
                @(negedge sys_clk);
                enable = 1'b0;
            end
        join
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
